// File: rtl/secded_decoder.sv
// secded_decoder: streams NUM_WORDS SECDED codewords from byte memory and writes back corrected data with error flags
module secded_decoder #(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       done,
  output logic [3:0] err1_cnt,
  output logic [3:0] err2_cnt
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [15:0] cw, cw_c;
  logic [3:0] syn;
  logic par, last, unused_bits;
  logic [1:0] flags;
  logic [10:0] data;
  logic [7:0] off, lo_byte, hi_byte;
  assign last = idx == IW'(NUM_WORDS - 1);
  assign off = 8'({idx, 1'b0});
  // syndrome is the XOR of the positions of every set bit
  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) syn ^= cw[k] ? 4'(k) : 4'd0;
  end
  assign par = ^cw;
  assign cw_c = par ? cw ^ (16'd1 << syn) : cw;
  assign flags = par ? 2'b01 : (syn != 4'd0 ? 2'b10 : 2'b00);
  assign data = {cw_c[15:9], cw_c[7:5], cw_c[3]};
  assign lo_byte = data[7:0];
  assign hi_byte = {flags, 3'b000, data[10:8]};
  assign unused_bits = ^{cw_c[8], cw_c[4], cw_c[2:0]};
  // next state and memory port; writes are suppressed while reset is pending so an abort writes nothing more
  always_comb begin
    state_nx = state;
    mem_addr = '0;
    mem_wr_en = 1'b0;
    mem_wr_data = '0;
    unique case (state)
      IDLE:  state_nx = RD_LO;
      RD_LO: begin
        mem_addr = 8'(SRC_BASE) + off;
        state_nx = RD_HI;
      end
      RD_HI: begin
        mem_addr = 8'(SRC_BASE) + off + 8'd1;
        state_nx = WR_LO;
      end
      WR_LO: begin
        mem_addr = 8'(DST_BASE) + off;
        mem_wr_en = ~reset;
        mem_wr_data = lo_byte;
        state_nx = WR_HI;
      end
      WR_HI: begin
        mem_addr = 8'(DST_BASE) + off + 8'd1;
        mem_wr_en = ~reset;
        mem_wr_data = hi_byte;
        state_nx = last ? DONE : RD_LO;
      end
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state, codeword latch, word index, saturating error counters and done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cw <= '0;
      done <= 1'b0;
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == RD_LO) cw[7:0] <= mem_rd_data;
      if (state == RD_HI) cw[15:8] <= mem_rd_data;
      if (state == WR_HI) begin
        idx <= last ? idx : idx + 1'b1;
        done <= last;
        err1_cnt <= err1_cnt + 4'(flags == 2'b01 && err1_cnt != 4'hf);
        err2_cnt <= err2_cnt + 4'(flags == 2'b10 && err2_cnt != 4'hf);
      end
    end
  end
endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: random and directed SECDED words checked against an encoder-based reference model
module tb_secded_decoder;
  localparam int SRC = 30, DST = 0, NW = 15;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic mem_wr_en, done;
  logic [3:0] err1_cnt, err2_cnt;
  logic [7:0] mem [256];
  logic [7:0] src_copy [2*NW];
  logic [15:0] expw [NW];
  int exp1, exp2, wr_count = 0, tests = 0, fails = 0;
  secded_decoder #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .done(done),
    .err1_cnt(err1_cnt), .err2_cnt(err2_cnt));
  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];
  // behavioural byte memory with a write-pulse counter
  always @(posedge clk) if (mem_wr_en) begin
    mem[mem_addr] <= mem_wr_data;
    wr_count <= wr_count + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Hamming(15,11) plus overall parity: data sits at non-power-of-two positions
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c = '0;
    int j = 0;
    for (int k = 3; k < 16; k++) if ((k & (k - 1)) != 0) begin
      c[k] = d[j];
      j++;
    end
    for (int b = 0; b < 4; b++)
      for (int k = 1; k < 16; k++) if (((k >> b) & 1) == 1 && k != (1 << b)) c[1 << b] ^= c[k];
    c[0] = ^c[15:1];
    return c;
  endfunction
  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d = '0;
    int j = 0;
    for (int k = 3; k < 16; k++) if ((k & (k - 1)) != 0) begin
      d[j] = c[k];
      j++;
    end
    return d;
  endfunction
  // fill memory: four directed words first, the rest random with 0/1/2 injected flips
  task automatic prep();
    logic [15:0] dir_cw [4] = '{16'hB42D, 16'hB40D, 16'hB42C, 16'hB60D};
    logic [15:0] dir_ex [4] = '{16'h05A3, 16'h45A3, 16'h45A3, 16'h85B1};
    int dir_n [4] = '{0, 1, 1, 2};
    exp1 = 0;
    exp2 = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < NW; i++) begin
      logic [15:0] c;
      logic [10:0] d;
      int n, p1, p2;
      if (i < 4) begin
        c = dir_cw[i];
        n = dir_n[i];
        expw[i] = dir_ex[i];
      end else begin
        d = 11'($urandom);
        c = encode(d);
        n = $urandom_range(0, 2);
        p1 = $urandom_range(0, 15);
        p2 = (p1 + $urandom_range(1, 15)) % 16;
        if (n >= 1) c[p1] = ~c[p1];
        if (n == 2) c[p2] = ~c[p2];
        expw[i] = n == 2 ? {2'b10, 3'b000, extract(c)} : {2'(n), 3'b000, d};
      end
      exp1 += int'(n == 1);
      exp2 += int'(n == 2);
      mem[SRC + 2*i] = c[7:0];
      mem[SRC + 2*i + 1] = c[15:8];
      src_copy[2*i] = c[7:0];
      src_copy[2*i + 1] = c[15:8];
    end
    for (int a = 0; a < 2*NW; a++) mem[DST + a] = 8'hEE;
  endtask
  // count edges from reset release until done rises, then check everything the run produced
  task automatic run_and_verify(input string tag);
    int rise = 0, base = wr_count, bad = 0;
    for (int e = 1; e <= 200 && rise == 0; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) rise = e;
    end
    check({tag, "_done_edge"}, rise, 1 + 4*NW);
    check({tag, "_wr_pulses"}, wr_count - base, 2*NW);
    check({tag, "_err1"}, err1_cnt, exp1);
    check({tag, "_err2"}, err2_cnt, exp2);
    for (int i = 0; i < NW; i++) begin
      check($sformatf("%s_lo%0d", tag, i), mem[DST + 2*i], expw[i][7:0]);
      check($sformatf("%s_hi%0d", tag, i), mem[DST + 2*i + 1], expw[i][15:8]);
    end
    for (int a = 0; a < 2*NW; a++) bad += int'(mem[SRC + a] !== src_copy[a]);
    check({tag, "_src_intact"}, bad, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, done, 1);
    check({tag, "_idle_addr"}, mem_addr, 0);
    check({tag, "_idle_wr"}, wr_count - base, 2*NW);
  endtask
  initial begin
    int base;
    prep();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err1", err1_cnt, 0);
    check("rst_err2", err2_cnt, 0);
    check("rst_no_writes", wr_count, 0);
    @(negedge clk) reset = 1'b0;
    run_and_verify("run1");
    prep();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_err1", err1_cnt, 0);
    check("rst2_done", done, 0);
    @(negedge clk) reset = 1'b0;
    base = wr_count;
    repeat (24) @(posedge clk);
    #1;
    check("abort_pre_done", done, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_writes", wr_count - base, 11);
    check("abort_done", done, 0);
    check("abort_addr", mem_addr, 0);
    for (int a = 0; a < 2*NW; a++) mem[DST + a] = 8'hEE;
    @(negedge clk) reset = 1'b0;
    run_and_verify("rerun");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/secded_decoder.md
SECDED_DECODER -- requirements
Module: secded_decoder

Interface
REQ-001 SHALL have parameter SRC_BASE, default 30, meaning the byte address of the first codeword's low byte.
REQ-002 SHALL have parameter DST_BASE, default 0, meaning the byte address of the first decoded word's low byte.
REQ-003 SHALL have parameter NUM_WORDS, default 15, meaning the number of 16-bit codewords processed per run.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset that also serves as the start request.
REQ-006 SHALL have port mem_addr, output, 8, the byte address to data memory.
REQ-007 SHALL have port mem_rd_data, input, 8, memory read data, combinational from mem_addr in the same cycle.
REQ-008 SHALL have port mem_wr_en, output, 1, the write strobe; memory writes mem_wr_data at mem_addr on the clock edge.
REQ-009 SHALL have port mem_wr_data, output, 8, the write data.
REQ-010 SHALL have port done, output, 1, high when all NUM_WORDS results are written.
REQ-011 SHALL have port err1_cnt, output, 4, the count of words with a single error corrected.
REQ-012 SHALL have port err2_cnt, output, 4, the count of words with a double error detected.

Function
REQ-013 Codeword i SHALL be {mem[SRC_BASE+2i+1], mem[SRC_BASE+2i]}, with bits b15..b0 = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
REQ-014 Syndrome S[3:0] SHALL be the XOR of indices k (1..15) of all set bits bk, and P SHALL be the XOR of all 16 bits.
REQ-015 Classification SHALL be: S=0,P=0 -> no error, flags 00; P=1 -> single error, flags 01, invert bit S (S=0 means p0, data unaffected); S!=0,P=0 -> double error, flags 10, data extracted uncorrected.
REQ-016 Output hi byte SHALL be {F1, F0, 3'b000, d11, d10, d9} and lo byte SHALL be {d8..d1}, written to DST_BASE+2i+1 and DST_BASE+2i.
REQ-017 FSM states SHALL be IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-018 IDLE SHALL go to RD_LO on the first edge with reset low.
REQ-019 RD_LO SHALL drive mem_addr=SRC_BASE+2i and latch the low byte.
REQ-020 RD_HI SHALL drive mem_addr=SRC_BASE+2i+1 and latch the high byte.
REQ-021 WR_LO SHALL write the lo byte with mem_wr_en=1.
REQ-022 WR_HI SHALL write the hi byte with mem_wr_en=1, update the counters, then go to RD_LO with i+1, or to DONE when i=NUM_WORDS-1.
REQ-023 Decode SHALL be combinational from the latched codeword; the block SHALL take exactly 4 cycles per word.
REQ-024 done SHALL be registered, rising on the 1+4*NUM_WORDS-th edge after reset deasserts (61 for default), and holding high in DONE until the next reset.
REQ-025 mem_wr_en SHALL be 0 in every state other than WR_LO/WR_HI; mem_addr and mem_wr_data SHALL be 0 in IDLE/DONE.
REQ-026 Counters SHALL saturate at 15 and SHALL never wrap.
REQ-027 The word index SHALL be wide enough for NUM_WORDS; address arithmetic SHALL be 8-bit and the block SHALL not check wrap (integration ensures ranges fit).
REQ-028 The block SHALL never write source addresses; overlapping SRC/DST ranges are unsupported.

Reset
REQ-029 While reset=1 at an edge: state=IDLE, i=0, done=0, err1_cnt=err2_cnt=0, latched codeword=0, mem_wr_en=0.
REQ-030 Reset asserted mid-run SHALL abort at the next edge with no further writes, then restart from word 0 after deassertion; partial results already written remain.
REQ-031 Reset held for multiple cycles SHALL keep the block in IDLE with no memory activity.

Verification
REQ-032 Clean codeword 0xB42D (data 0x5A3) -> written hi 0x05, lo 0xA3, err1/err2 unchanged.
REQ-033 Bit 5 flipped (0xB40D) -> hi 0x45, lo 0xA3, err1_cnt+1.
REQ-034 Only p0 flipped (0xB42C) -> hi 0x45, lo 0xA3, err1_cnt+1.
REQ-035 Bits 5 and 9 flipped (0xB60D) -> hi 0x85, lo 0xB1, err2_cnt+1.
REQ-036 15 random words with 0/1/2 flips compared against a reference model -> all 30 bytes match, done rises exactly at edge 61, mem_wr_en pulses exactly 30 times, and counters equal the injected counts.
REQ-037 Reset pulsed at edge 25 mid-run -> done stays low, then the rerun completes at edge 61 after the second deassert with correct results.
